// File: rtl/fpu_result_stage_pkg.sv
// Shared definitions for the FPU result stage: 8-bit FP constants,
// exception codes, sticky flag bit positions and output queue states.
package fpu_result_stage_pkg;

  // 8-bit format: sign[7], exp[6:3], mant[2:0]
  localparam logic [7:0] PLUS_INF  = 8'h78;
  localparam logic [7:0] MINUS_INF = 8'hF8;
  localparam logic [7:0] FP_QNAN   = 8'h7C;
  localparam logic [7:0] FP_ZERO   = 8'h00;

  // Exception checker codes; 5..7 carry no special-result meaning
  localparam logic [2:0] EXCE_NO       = 3'd0;
  localparam logic [2:0] EXCE_QNAN     = 3'd1;
  localparam logic [2:0] EXCE_SNAN     = 3'd2;
  localparam logic [2:0] EXCE_INF      = 3'd3;
  localparam logic [2:0] EXCE_ZERO_DIV = 3'd4;

  // Sticky flag bit positions: {SNAN, INVALID, DIVZERO, OVF, UNF}
  localparam int FLAG_SNAN    = 4;
  localparam int FLAG_INVALID = 3;
  localparam int FLAG_DIVZERO = 2;
  localparam int FLAG_OVF     = 1;
  localparam int FLAG_UNF     = 0;
  localparam int FLAG_W       = 5;

  // Output queue occupancy
  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } q_state_e;

  // Zero of either sign
  function automatic logic is_zero(input logic [7:0] v);
    return (v[6:0] == 7'd0);
  endfunction

endpackage

// File: rtl/fpu_special_result.sv
// Combinational resolution of the final result, exception code and the
// flag bits contributed by one operation.
module fpu_special_result
  import fpu_result_stage_pkg::*;
(
  input  logic              op_is_exception,
  input  logic [2:0]        fp_exce,
  input  logic [7:0]        op_a,
  input  logic              sign_b,
  input  logic [7:0]        arith_result,
  input  logic              arith_ovf,
  input  logic              arith_unf,
  output logic [7:0]        result,
  output logic [2:0]        result_exce,
  output logic [FLAG_W-1:0] flags
);

  // Substitute special results when the checker flags an exception;
  // datapath overflow/underflow only count for non-exception ops.
  always_comb begin
    result      = arith_result;
    result_exce = EXCE_NO;
    flags       = '0;
    if (!op_is_exception) begin
      flags[FLAG_OVF] = arith_ovf;
      flags[FLAG_UNF] = arith_unf;
    end else begin
      result_exce = fp_exce;
      case (fp_exce)
        EXCE_QNAN: begin
          result = FP_QNAN;
        end
        EXCE_SNAN: begin
          result              = FP_QNAN;
          flags[FLAG_SNAN]    = 1'b1;
          flags[FLAG_INVALID] = 1'b1;
        end
        EXCE_INF: begin
          result              = FP_QNAN;
          flags[FLAG_INVALID] = 1'b1;
        end
        EXCE_ZERO_DIV: begin
          if (is_zero(op_a)) begin
            // 0/0 is invalid rather than a divide-by-zero
            result              = FP_QNAN;
            flags[FLAG_INVALID] = 1'b1;
          end else begin
            result              = (op_a[7] ^ sign_b) ? MINUS_INF : PLUS_INF;
            flags[FLAG_DIVZERO] = 1'b1;
          end
        end
        default: begin
          // NO and the unused codes keep the datapath result
        end
      endcase
    end
  end

endmodule

// File: rtl/fpu_result_stage.sv
// FPU output stage: resolves special results, accumulates sticky flags and
// a saturating exception counter, and buffers results in a 2-entry queue.
module fpu_result_stage
  import fpu_result_stage_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [1:0]        FP_OPERATION,
  input  logic [7:0]        OP_A,
  input  logic [7:0]        OP_B,
  input  logic [7:0]        ARITH_RESULT,
  input  logic              ARITH_OVF,
  input  logic              ARITH_UNF,
  input  logic              OP_IS_EXCEPTION,
  input  logic [2:0]        FP_EXCE,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [7:0]        RESULT,
  output logic [2:0]        RESULT_EXCE,
  output logic [FLAG_W-1:0] STICKY_FLAGS,
  output logic [CNT_W-1:0]  EXCE_CNT,
  input  logic              FLAGS_CLR
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  q_state_e          state;
  logic [7:0]        tail_result;
  logic [2:0]        tail_exce;
  logic [7:0]        new_result;
  logic [2:0]        new_exce;
  logic [FLAG_W-1:0] new_flags;
  logic [FLAG_W-1:0] flags_base;
  logic [CNT_W-1:0]  cnt_base;
  logic              push;
  logic              pop;

  // The opcode and operand B magnitude do not affect resolution
  logic unused_inputs;
  assign unused_inputs = ^{FP_OPERATION, OP_B[6:0]};

  fpu_special_result u_special (
    .op_is_exception (OP_IS_EXCEPTION),
    .fp_exce         (FP_EXCE),
    .op_a            (OP_A),
    .sign_b          (OP_B[7]),
    .arith_result    (ARITH_RESULT),
    .arith_ovf       (ARITH_OVF),
    .arith_unf       (ARITH_UNF),
    .result          (new_result),
    .result_exce     (new_exce),
    .flags           (new_flags)
  );

  assign IN_READY  = (state != Q_FULL);
  assign OUT_VALID = (state != Q_EMPTY);
  assign push      = IN_VALID && IN_READY;
  assign pop       = OUT_VALID && OUT_READY;

  // A clear wipes the old state first so a same-cycle event still lands
  assign flags_base = FLAGS_CLR ? '0 : STICKY_FLAGS;
  assign cnt_base   = FLAGS_CLR ? '0 : EXCE_CNT;

  // Queue FSM: RESULT/RESULT_EXCE are the registered head entry
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= Q_EMPTY;
      RESULT      <= FP_ZERO;
      RESULT_EXCE <= EXCE_NO;
      tail_result <= FP_ZERO;
      tail_exce   <= EXCE_NO;
    end else begin
      case (state)
        Q_EMPTY: begin
          if (push) begin
            RESULT      <= new_result;
            RESULT_EXCE <= new_exce;
            state       <= Q_ONE;
          end
        end
        Q_ONE: begin
          if (push && pop) begin
            RESULT      <= new_result;
            RESULT_EXCE <= new_exce;
          end else if (push) begin
            tail_result <= new_result;
            tail_exce   <= new_exce;
            state       <= Q_FULL;
          end else if (pop) begin
            state <= Q_EMPTY;
          end
        end
        Q_FULL: begin
          if (pop) begin
            RESULT      <= tail_result;
            RESULT_EXCE <= tail_exce;
            state       <= Q_ONE;
          end
        end
        default: state <= Q_EMPTY;
      endcase
    end
  end

  // Sticky flags and saturating exception counter update on accept
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      STICKY_FLAGS <= '0;
      EXCE_CNT     <= '0;
    end else begin
      STICKY_FLAGS <= flags_base | (push ? new_flags : '0);
      if (push && OP_IS_EXCEPTION && (cnt_base != CNT_MAX))
        EXCE_CNT <= cnt_base + 1'b1;
      else
        EXCE_CNT <= cnt_base;
    end
  end

endmodule
